// File: rtl/bg_theme_sequencer.sv
// Background theme sequencer: owns the fill/border colours (RRRGGGBB) seen by
// the background drawer and walks them through a frame-locked fade-out /
// theme-switch / fade-in whenever game logic asks for a different theme.
//
// Handshake: themeReq is a one-cycle pulse that is always accepted; themeAck
// answers one cycle later. busy is high from the cycle after an accepted
// change until the cycle the final fade-in colour lands. A request seen while
// busy is parked in a single pending slot (newest wins) and served afterwards.
module bg_theme_sequencer #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       themeReq,
  input  logic [1:0] themeSel,
  output logic       themeAck,
  output logic       busy,
  output logic [7:0] fillRGB,
  output logic [7:0] borderRGB
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_t;

  localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);

  // state_q is the FSM state; bind checkers to it directly
  state_t     state_q;
  state_t     state_d;
  logic [1:0] cur_theme;
  logic [1:0] tgt_theme;
  logic [1:0] pend_theme;
  logic       pend_valid;
  logic [3:0] frame_cnt;

  logic       in_fade;
  logic       step;
  logic [7:0] goal_fill;
  logic [7:0] goal_border;
  logic [7:0] dim_fill;
  logic [7:0] dim_border;
  logic [7:0] lit_fill;
  logic [7:0] lit_border;
  logic [7:0] fill_d;
  logic [7:0] border_d;
  logic       busy_d;

  function automatic logic [7:0] theme_fill(input logic [1:0] sel);
    logic [7:0] c;
    case (sel)
      2'd0:    c = 8'h58;
      2'd1:    c = 8'h02;
      2'd2:    c = 8'h6D;
      default: c = 8'h88;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] theme_border(input logic [1:0] sel);
    logic [7:0] c;
    case (sel)
      2'd0:    c = 8'hFC;
      2'd1:    c = 8'hFF;
      2'd2:    c = 8'hE0;
      default: c = 8'hFC;
    endcase
    return c;
  endfunction

  // One step darker: every channel drops by one, stopping at zero
  function automatic logic [7:0] fade_down(input logic [7:0] c);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = (c[7:5] != 3'd0) ? c[7:5] - 3'd1 : 3'd0;
    g = (c[4:2] != 3'd0) ? c[4:2] - 3'd1 : 3'd0;
    b = (c[1:0] != 2'd0) ? c[1:0] - 2'd1 : 2'd0;
    return {r, g, b};
  endfunction

  // One step brighter: every channel rises by one, stopping at the goal
  function automatic logic [7:0] fade_up(input logic [7:0] c, input logic [7:0] t);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = (c[7:5] < t[7:5]) ? c[7:5] + 3'd1 : t[7:5];
    g = (c[4:2] < t[4:2]) ? c[4:2] + 3'd1 : t[4:2];
    b = (c[1:0] < t[1:0]) ? c[1:0] + 2'd1 : t[1:0];
    return {r, g, b};
  endfunction

  // Frames only advance the fade while a fade is running
  assign in_fade     = (state_q != IDLE);
  assign step        = in_fade && startOfFrame && (frame_cnt == STEP_LAST);
  assign goal_fill   = theme_fill(cur_theme);
  assign goal_border = theme_border(cur_theme);
  assign dim_fill    = fade_down(fillRGB);
  assign dim_border  = fade_down(borderRGB);
  assign lit_fill    = fade_up(fillRGB, goal_fill);
  assign lit_border  = fade_up(borderRGB, goal_border);

  // FSM state register
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a fresh request in IDLE outranks a parked one
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (themeReq) begin
          if (themeSel != cur_theme) state_d = FADE_OUT;
        end else if (pend_valid && (pend_theme != cur_theme)) begin
          state_d = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (step && (dim_fill == 8'h00) && (dim_border == 8'h00)) state_d = FADE_IN;
      end
      FADE_IN: begin
        if (step && (lit_fill == goal_fill) && (lit_border == goal_border)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: next colour values and busy, registered below
  always_comb begin
    fill_d   = fillRGB;
    border_d = borderRGB;
    busy_d   = (state_d != IDLE);
    if (step && (state_q == FADE_OUT)) begin
      fill_d   = dim_fill;
      border_d = dim_border;
    end else if (step && (state_q == FADE_IN)) begin
      fill_d   = lit_fill;
      border_d = lit_border;
    end
  end

  // Registered outputs; reset shows theme 0 straight away
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      themeAck  <= 1'b0;
      busy      <= 1'b0;
      fillRGB   <= 8'h58;
      borderRGB <= 8'hFC;
    end else begin
      themeAck  <= themeReq;
      busy      <= busy_d;
      fillRGB   <= fill_d;
      borderRGB <= border_d;
    end
  end

  // Theme bookkeeping: target, pending slot, and the active theme swap at black
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      cur_theme  <= 2'd0;
      tgt_theme  <= 2'd0;
      pend_theme <= 2'd0;
      pend_valid <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (themeReq) begin
          pend_valid <= 1'b0;
          if (themeSel != cur_theme) tgt_theme <= themeSel;
        end else if (pend_valid) begin
          // Either consumed into a new fade or dropped as already shown
          pend_valid <= 1'b0;
          if (pend_theme != cur_theme) tgt_theme <= pend_theme;
        end
      end else if (themeReq) begin
        pend_valid <= 1'b1;
        pend_theme <= themeSel;
      end
      if ((state_q == FADE_OUT) && (state_d == FADE_IN)) cur_theme <= tgt_theme;
    end
  end

  // Frame divider: restarts on every fade start and after every step
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      frame_cnt <= 4'd0;
    end else if ((state_q != FADE_OUT) && (state_d == FADE_OUT)) begin
      frame_cnt <= 4'd0;
    end else if (in_fade && startOfFrame) begin
      frame_cnt <= step ? 4'd0 : frame_cnt + 4'd1;
    end
  end

endmodule

// File: doc/bg_theme_sequencer.md
# bg_theme_sequencer

Controller that configures the background drawer's colour scheme. It holds the active fill and border colours (8-bit RRRGGGBB) that the background drawing block consumes. It serves theme-change requests from game logic with a frame-synchronised fade: fade to black, switch theme, fade in. All colour updates happen only on frame boundaries, so a frame never tears mid-scan.

## Interface
Parameters:
- FRAMES_PER_STEP, default 4: number of startOfFrame pulses per fade step (legal range 1..15).

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous and active-high (asserted = 1).
- startOfFrame  in  1  single-cycle pulse, first pixel of each frame.
- themeReq  in  1  single-cycle request pulse.
- themeSel  in  2  requested theme index, sampled when themeReq=1.
- themeAck  out  1  single-cycle pulse, request accepted.
- busy  out  1  high while a fade is in progress.
- fillRGB  out  8  background fill colour, RRRGGGBB.
- borderRGB  out  8  border/bracket colour, RRRGGGBB.

## Operation
- Fixed theme table (fill / border):
  - 0: 0x58 / 0xFC
  - 1: 0x02 / 0xFF
  - 2: 0x6D / 0xE0
  - 3: 0x88 / 0xFC
- Registers:
  - curTheme[1:0]
  - tgtTheme[1:0]
  - pendValid
  - pendTheme[1:0]
  - frameCnt[3:0]
  - fillRGB, borderRGB
  - FSM state
- FSM states:
  - IDLE to FADE_OUT: taken on an accepted request whose theme differs from curTheme, or on pendValid (the pending slot is consumed).
  - FADE_OUT to FADE_IN: taken on the step at which both fillRGB and borderRGB reach 0x00. curTheme takes the value of tgtTheme on the same step.
  - FADE_IN to IDLE: taken on the step at which both outputs equal the table entry for curTheme.
- Step event: startOfFrame=1 and frameCnt==FRAMES_PER_STEP-1. On a step, frameCnt clears to 0. Otherwise each startOfFrame increments frameCnt, and only while busy. frameCnt clears on entry to FADE_OUT.
- Fade-out step: each channel is decremented by 1, saturating at 0. Channels are R[7:5] and G[4:2] (range 0..7) and B[1:0] (range 0..3). The rule applies to both outputs.
- Fade-in step: each channel is incremented by 1, saturating at the target channel value.
- Requests are always accepted. themeAck pulses the cycle after themeReq.
  - IDLE, themeSel==curTheme: ack only. No fade, busy stays 0.
  - IDLE, different theme: tgtTheme is set to themeSel and the FSM goes to FADE_OUT.
  - Busy: pendTheme is set to themeSel and pendValid to 1. The latest request overwrites any earlier pending one.
- On entering IDLE with pendValid=1:
  - pendTheme == curTheme: the pending request is dropped.
  - Otherwise: the FSM re-enters FADE_OUT on the next cycle.
- busy = (state != IDLE).
- Without startOfFrame pulses, the outputs hold indefinitely.

## Timing
- Reset values (applied immediately, asynchronously):
  - State IDLE; curTheme and tgtTheme 0.
  - fillRGB=0x58, borderRGB=0xFC.
  - busy=0, themeAck=0, pendValid=0, frameCnt=0.
- Reset mid-fade aborts the fade and discards pending requests.
- All outputs are registered.
  - Colour changes become visible the cycle after the startOfFrame that caused the step.
  - busy deasserts in that same cycle as the final fade-in colour change.
- Request latency: themeReq at cycle t gives themeAck=1 and busy=1 at t+1.
- themeReq and startOfFrame in the same cycle while IDLE: the request is accepted and that startOfFrame is not counted.
- First fade step: the FRAMES_PER_STEP-th startOfFrame after acceptance.
- Fade durations:
  - Fade-out: steps = largest current channel value across both outputs.
  - Fade-in: steps = largest target channel value.
- Back-to-back fades (pending): one idle cycle between busy falling and busy rising again.

## Test plan
- Reset, then idle for 10 frames -> fillRGB=0x58, borderRGB=0xFC, busy=0, no themeAck.
- FRAMES_PER_STEP=2, themeReq with themeSel=1 at t, startOfFrame every 100 cycles:
  - themeAck at t+1 only.
  - After the 2nd startOfFrame, fill=0x34 and border=0xD8.
  - After the 14th, both are 0x00.
  - After the 28th, fill=0x02, border=0xFF, busy=0.
- While IDLE on theme 0, request theme 0 -> themeAck pulse, busy stays 0, outputs unchanged.
- During the fade to theme 1, request theme 2 then theme 3 -> both acked. After theme 1 completes, one idle cycle, then a fade ends at 0x88/0xFC; theme 2 never appears.
- Assert resetN in the middle of a fade-out -> outputs 0x58/0xFC immediately, busy=0, and no pending fade after reset is released.
- Start a fade, then withhold startOfFrame for 1000 cycles -> outputs and busy unchanged until the next pulse.
